// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus IDLE/EXEC/CAPT/RESP sequencer in front of a 1-cycle registered 4-bit ALU.
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the rsp_zero response flag.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic [2:0] rsp_op,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic       rsp_zero,
`endif
    output logic       busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [10:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;
    logic          load_rsp_s;
    logic          clr_rsp_s;
    logic [10:0]   head_s;

    assign cmd_ready = (count_r < CW'(DEPTH));
    assign push_s    = cmd_valid & cmd_ready;
    assign head_s    = mem_r[rd_ptr_r];
    assign busy      = (count_r != {CW{1'b0}}) || (state_r != ST_IDLE);

    // FIFO storage: entries packed as {op, a, b}
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        load_rsp_s  = 1'b0;
        clr_rsp_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_CAPT;
            ST_CAPT: begin
                load_rsp_s  = 1'b1;
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    clr_rsp_s = 1'b1;
                    if (count_r != {CW{1'b0}}) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ALU operand registers only move on a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= 3'd0;
            alu_a  <= 4'd0;
            alu_b  <= 4'd0;
        end else if (pop_s) begin
            alu_op <= head_s[10:8];
            alu_a  <= head_s[7:4];
            alu_b  <= head_s[3:0];
        end
    end

    // Response capture; payload holds until the next CAPT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
            rsp_op     <= 3'd0;
        end else if (load_rsp_s) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_op     <= alu_op;
        end else if (clr_rsp_s) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    // Zero flag captured alongside the rest of the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
        end else if (load_rsp_s) begin
            rsp_zero <= (alu_result == 4'b0000);
        end
    end
`endif

endmodule
